// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : capture_sequencer
//  Brief    : Sample-capture controller. Generates the decimated SRAM write
//             strobe and circular write address, gates trigger acceptance by
//             pre-trigger fill, counts the post-trigger window and reports
//             completion plus the trigger address.
//  Revision : 1.0  initial release
// ============================================================================
module capture_sequencer #(
   parameter int ADDR_W = 18,
   parameter int DEC_W  = 24
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              Start_Write_s,
   input  logic              Enable_Trigger,
   input  logic              Trigger_event,
   input  logic [DEC_W-1:0]  Decimation,
   input  logic [ADDR_W-1:0] WIN_DATA,
   input  logic [7:0]        Delay,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE,
   output logic              Triggered,
   output logic [ADDR_W-1:0] Trigger_Addr,
   output logic              Capture_Done,
   output logic [2:0]        State
);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_PRE   = 3'd1;
   localparam logic [2:0] c_ST_ARMED = 3'd2;
   localparam logic [2:0] c_ST_POST  = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic              r_start_d;
   logic [DEC_W-1:0]  r_div_cnt;
   logic [7:0]        r_pre_cnt;
   logic [ADDR_W-1:0] r_post_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic              r_trig;
   logic [ADDR_W-1:0] r_trig_addr;
   logic              r_done;

   logic              w_start_edge;
   logic              w_running;
   logic              w_div_hit;
   logic              w_accept;
   logic              w_post_full;
   logic              w_tick;
   logic              w_pre_last;

   // State register
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; a dropped run level always wins over progress
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_start_edge) begin
               w_next_state = (Delay != 8'd0) ? c_ST_PRE : c_ST_ARMED;
            end
         end
         c_ST_PRE: begin
            if (!Start_Write_s)  w_next_state = c_ST_IDLE;
            else if (w_pre_last) w_next_state = c_ST_ARMED;
         end
         c_ST_ARMED: begin
            if (!Start_Write_s) w_next_state = c_ST_IDLE;
            else if (w_accept)  w_next_state = c_ST_POST;
         end
         c_ST_POST: begin
            if (!Start_Write_s)   w_next_state = c_ST_IDLE;
            else if (w_post_full) w_next_state = c_ST_DONE;
         end
         c_ST_DONE: begin
            if (!Start_Write_s) w_next_state = c_ST_IDLE;
         end
         default: w_next_state = c_ST_IDLE;
      endcase
   end

   // Control decode: start edge, sample tick, trigger acceptance, window end.
   // Once the post window is full no further tick is issued, and with an
   // empty window a tick coincident with acceptance would be a post sample,
   // so it is suppressed too.
   always_comb begin
      w_start_edge = (r_state == c_ST_IDLE) && Start_Write_s && !r_start_d;
      w_running    = (r_state == c_ST_PRE) || (r_state == c_ST_ARMED) ||
                     (r_state == c_ST_POST);
      w_div_hit    = w_running && (r_div_cnt == Decimation);
      w_accept     = (r_state == c_ST_ARMED) && Start_Write_s &&
                     (!Enable_Trigger || Trigger_event);
      w_post_full  = (r_state == c_ST_POST) && (r_post_cnt >= WIN_DATA);
      w_tick       = w_div_hit && !w_post_full &&
                     !(w_accept && (WIN_DATA == '0));
      w_pre_last   = (r_state == c_ST_PRE) && w_tick &&
                     (({1'b0, r_pre_cnt} + 9'd1) >= {1'b0, Delay});
   end

   // Datapath: divider, counters, write strobe/address and status flags
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_start_d   <= 1'b0;
         r_div_cnt   <= '0;
         r_pre_cnt   <= 8'd0;
         r_post_cnt  <= '0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_trig      <= 1'b0;
         r_trig_addr <= '0;
         r_done      <= 1'b0;
      end else begin
         r_start_d <= Start_Write_s;
         r_we      <= w_tick;
         // The address advances as each write cycle ends, wrapping freely
         if (r_we) begin
            r_addr <= r_addr + ADDR_W'(1);
         end
         if (w_start_edge) begin
            r_div_cnt   <= '0;
            r_pre_cnt   <= 8'd0;
            r_post_cnt  <= '0;
            r_addr      <= '0;
            r_trig      <= 1'b0;
            r_trig_addr <= '0;
            r_done      <= 1'b0;
         end else begin
            if (w_running) begin
               r_div_cnt <= w_div_hit ? '0 : r_div_cnt + DEC_W'(1);
            end
            if ((r_state == c_ST_PRE) && w_tick) begin
               r_pre_cnt <= r_pre_cnt + 8'd1;
            end
            if (w_accept) begin
               r_trig      <= 1'b1;
               // Next write address: skip over a write still in flight
               r_trig_addr <= r_we ? r_addr + ADDR_W'(1) : r_addr;
               r_post_cnt  <= w_tick ? ADDR_W'(1) : '0;
            end else if ((r_state == c_ST_POST) && w_tick) begin
               r_post_cnt <= r_post_cnt + ADDR_W'(1);
            end
            if (w_post_full && Start_Write_s) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   assign SRAM_ADDR    = r_addr;
   assign SRAM_WE      = r_we;
   assign Triggered    = r_trig;
   assign Trigger_Addr = r_trig_addr;
   assign Capture_Done = r_done;
   assign State        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_sequencer
//  Brief    : Self-checking bench for capture_sequencer. A narrow address
//             width keeps the wrap scenario short.
//  Revision : 1.0  initial release
// ============================================================================
module tb_capture_sequencer;

   localparam int AW = 10;
   localparam int DW = 24;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          Start_Write_s;
   logic          Enable_Trigger;
   logic          Trigger_event;
   logic [DW-1:0] Decimation;
   logic [AW-1:0] WIN_DATA;
   logic [7:0]    Delay;
   logic [AW-1:0] SRAM_ADDR;
   logic          SRAM_WE;
   logic          Triggered;
   logic [AW-1:0] Trigger_Addr;
   logic          Capture_Done;
   logic [2:0]    State;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int s_cyc = 0;
   bit rec   = 1'b0;
   int we_addr[$];
   int we_cyc[$];

   capture_sequencer #(.ADDR_W(AW), .DEC_W(DW)) dut (
      .CLK(CLK), .nRST(nRST), .Start_Write_s(Start_Write_s),
      .Enable_Trigger(Enable_Trigger), .Trigger_event(Trigger_event),
      .Decimation(Decimation), .WIN_DATA(WIN_DATA), .Delay(Delay),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_WE(SRAM_WE), .Triggered(Triggered),
      .Trigger_Addr(Trigger_Addr), .Capture_Done(Capture_Done), .State(State)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every write cycle (address and cycle index) while a run is open
   always @(negedge CLK) begin
      if (rec && SRAM_WE === 1'b1) begin
         we_addr.push_back(int'(SRAM_ADDR));
         we_cyc.push_back(cyc);
      end
   end

   task automatic start_run(input int d, input int dly, input int win, input int et);
      @(negedge CLK);
      Decimation     = DW'(d);
      Delay          = 8'(dly);
      WIN_DATA       = AW'(win);
      Enable_Trigger = (et != 0);
      we_addr.delete();
      we_cyc.delete();
      rec           = 1'b1;
      Start_Write_s = 1'b1;
      s_cyc         = cyc;
   endtask

   task automatic wait_done(input int budget, output bit to, output int dcyc);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (Capture_Done !== 1'b1 && n < budget);
      to   = (Capture_Done !== 1'b1);
      dcyc = cyc;
   endtask

   task automatic end_run();
      @(negedge CLK);
      Start_Write_s = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      rec = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; Start_Write_s = 1'b0; Enable_Trigger = 1'b0; Trigger_event = 1'b0;
      Decimation = '0; WIN_DATA = '0; Delay = 8'd0;
      repeat (2) @(negedge CLK);
      total++;
      if ({State, SRAM_ADDR, SRAM_WE, Triggered, Trigger_Addr, Capture_Done} !== '0) begin
         bad++;
         $display("FAIL reset: state=%0d addr=%0d we=%b trg=%b taddr=%0d done=%b want all 0",
                  State, SRAM_ADDR, SRAM_WE, Triggered, Trigger_Addr, Capture_Done);
      end
      nRST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_free_run(input int d);
      bit to; int dc; int exp_dc;
      start_run(d, 4, 10, 0);
      wait_done(500, to, dc);
      exp_dc = s_cyc + 2 + d + 13 * (d + 1) + 1;
      total++;
      if (to) begin bad++; $display("FAIL free_run_d%0d timeout: done=%b want 1", d, Capture_Done); end
      total++;
      if (dc != exp_dc) begin bad++; $display("FAIL free_run_d%0d done_cycle: got %0d want %0d", d, dc - s_cyc, exp_dc - s_cyc); end
      total++;
      if (State !== 3'd4 || Triggered !== 1'b1) begin
         bad++; $display("FAIL free_run_d%0d state: got state=%0d trg=%b want 4/1", d, State, Triggered);
      end
      total++;
      if (Trigger_Addr !== AW'(4)) begin bad++; $display("FAIL free_run_d%0d trig_addr: got %0d want 4", d, Trigger_Addr); end
      end_run();
      total++;
      if (State !== 3'd0 || Capture_Done !== 1'b1) begin
         bad++; $display("FAIL free_run_d%0d idle_hold: got state=%0d done=%b want 0/1", d, State, Capture_Done);
      end
      total++;
      if (we_addr.size() != 14) begin bad++; $display("FAIL free_run_d%0d we_count: got %0d want 14", d, we_addr.size()); end
      for (int i = 0; i < we_addr.size(); i++) begin
         total++;
         if (we_addr[i] != i || we_cyc[i] != s_cyc + 2 + d + i * (d + 1)) begin
            bad++;
            $display("FAIL free_run_d%0d write%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                     d, i, we_addr[i], we_cyc[i] - s_cyc, i, 2 + d + i * (d + 1));
         end
      end
   endtask

   task automatic test_trigger_gating();
      bit to; int dc; int n; int pcyc; int post;
      start_run(3, 8, 6, 1);
      repeat (10) @(negedge CLK);
      Trigger_event = 1'b1;
      @(negedge CLK);
      Trigger_event = 1'b0;
      total++;
      if (Triggered !== 1'b0 || State !== 3'd1) begin
         bad++; $display("FAIL gating_pre: got trg=%b state=%0d want 0/1", Triggered, State);
      end
      n = 0;
      while (!(State === 3'd2 && SRAM_ADDR === AW'(20) && SRAM_WE === 1'b0) && n < 300) begin
         @(negedge CLK); n++;
      end
      total++;
      if (n >= 300) begin bad++; $display("FAIL gating_wait: got addr=%0d state=%0d want addr 20 armed", SRAM_ADDR, State); end
      pcyc = cyc;
      Trigger_event = 1'b1;
      @(negedge CLK);
      Trigger_event = 1'b0;
      total++;
      if (Triggered !== 1'b1 || Trigger_Addr !== AW'(20) || State !== 3'd3) begin
         bad++; $display("FAIL gating_accept: got trg=%b taddr=%0d state=%0d want 1/20/3", Triggered, Trigger_Addr, State);
      end
      wait_done(500, to, dc);
      total++;
      if (to) begin bad++; $display("FAIL gating_done timeout: done=%b want 1", Capture_Done); end
      end_run();
      post = 0;
      foreach (we_cyc[i]) if (we_cyc[i] > pcyc) post++;
      total++;
      if (post != 6 || we_addr.size() != 26) begin
         bad++; $display("FAIL gating_count: got post=%0d total=%0d want 6/26", post, we_addr.size());
      end
      total++;
      if (we_addr.size() > 0 && we_addr[we_addr.size() - 1] != 25) begin
         bad++; $display("FAIL gating_last_addr: got %0d want 25", we_addr[we_addr.size() - 1]);
      end
   endtask

   task automatic test_wrap();
      bit to; int dc; int n; int nw;
      start_run(0, 255, 5, 1);
      n = 0;
      while (!(State === 3'd2 && SRAM_ADDR === AW'((1 << AW) - 1)) && n < 3000) begin
         @(negedge CLK); n++;
      end
      total++;
      if (n >= 3000) begin bad++; $display("FAIL wrap_wait: got addr=%0d state=%0d want top addr armed", SRAM_ADDR, State); end
      Trigger_event = 1'b1;
      @(negedge CLK);
      Trigger_event = 1'b0;
      total++;
      if (Triggered !== 1'b1 || Trigger_Addr !== AW'(0)) begin
         bad++; $display("FAIL wrap_trig_addr: got trg=%b taddr=%0d want 1/0", Triggered, Trigger_Addr);
      end
      wait_done(100, to, dc);
      total++;
      if (to) begin bad++; $display("FAIL wrap_done timeout: done=%b want 1", Capture_Done); end
      end_run();
      nw = (1 << AW) + 5;
      total++;
      if (we_addr.size() != nw) begin bad++; $display("FAIL wrap_count: got %0d want %0d", we_addr.size(), nw); end
      for (int i = 0; i < we_addr.size(); i++) begin
         total++;
         if (we_addr[i] != i % (1 << AW)) begin
            bad++; $display("FAIL wrap_write%0d: got addr=%0d want %0d", i, we_addr[i], i % (1 << AW));
         end
      end
   endtask

   task automatic test_abort_win0();
      int n;
      start_run(1, 2, 5, 1);
      n = 0;
      while (State !== 3'd2 && n < 50) begin @(negedge CLK); n++; end
      Start_Write_s = 1'b0;
      @(negedge CLK);
      total++;
      if (State !== 3'd0 || Capture_Done !== 1'b0 || Triggered !== 1'b0) begin
         bad++; $display("FAIL abort: got state=%0d done=%b trg=%b want 0/0/0", State, Capture_Done, Triggered);
      end
      repeat (3) @(negedge CLK);
      rec = 1'b0;
      start_run(0, 0, 0, 0);
      @(negedge CLK);
      total++;
      if (State !== 3'd2) begin bad++; $display("FAIL win0_armed: got state=%0d want 2", State); end
      @(negedge CLK);
      total++;
      if (State !== 3'd3 || Triggered !== 1'b1) begin bad++; $display("FAIL win0_post: got state=%0d trg=%b want 3/1", State, Triggered); end
      @(negedge CLK);
      total++;
      if (State !== 3'd4 || Capture_Done !== 1'b1 || Trigger_Addr !== AW'(0)) begin
         bad++; $display("FAIL win0_done: got state=%0d done=%b taddr=%0d want 4/1/0", State, Capture_Done, Trigger_Addr);
      end
      end_run();
      total++;
      if (we_addr.size() != 0) begin bad++; $display("FAIL win0_writes: got %0d want 0", we_addr.size()); end
   endtask

   // Free-run captures with random settings: the run writes Delay+WIN_DATA
   // consecutive samples spaced D+1 apart starting D+2 clocks after the start
   // edge, the trigger lands on sample index Delay, and an empty window ends
   // two clocks after arming.
   task automatic test_random();
      bit to; int dc; int d; int dly; int win; int nexp; int a; int exp_dc;
      for (int it = 0; it < 8; it++) begin
         d   = $urandom_range(0, 3);
         dly = $urandom_range(0, 12);
         win = $urandom_range(0, 20);
         start_run(d, dly, win, 0);
         wait_done(400, to, dc);
         nexp = dly + win;
         a    = dly * (d + 1) + 1;
         exp_dc = (win == 0) ? s_cyc + a + 2 : s_cyc + 2 + d + (nexp - 1) * (d + 1) + 1;
         total++;
         if (to || dc != exp_dc) begin
            bad++; $display("FAIL rand%0d done_cycle: got %0d want %0d (d=%0d dly=%0d win=%0d)",
                            it, dc - s_cyc, exp_dc - s_cyc, d, dly, win);
         end
         total++;
         if (Trigger_Addr !== AW'(dly) || Triggered !== 1'b1) begin
            bad++; $display("FAIL rand%0d trig: got taddr=%0d trg=%b want %0d/1", it, Trigger_Addr, Triggered, dly);
         end
         end_run();
         total++;
         if (we_addr.size() != nexp) begin bad++; $display("FAIL rand%0d count: got %0d want %0d", it, we_addr.size(), nexp); end
         for (int i = 0; i < we_addr.size(); i++) begin
            total++;
            if (we_addr[i] != i || we_cyc[i] != s_cyc + 2 + d + i * (d + 1)) begin
               bad++; $display("FAIL rand%0d write%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                               it, i, we_addr[i], we_cyc[i] - s_cyc, i, 2 + d + i * (d + 1));
            end
         end
      end
   endtask

   task automatic test_reset_mid_post();
      int n; int wes;
      start_run(1, 2, 50, 0);
      n = 0;
      while (State !== 3'd3 && n < 50) begin @(negedge CLK); n++; end
      nRST = 1'b0;
      Start_Write_s = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      total++;
      if ({State, SRAM_ADDR, SRAM_WE, Triggered, Trigger_Addr, Capture_Done} !== '0) begin
         bad++;
         $display("FAIL reset_post: state=%0d addr=%0d we=%b trg=%b taddr=%0d done=%b want all 0",
                  State, SRAM_ADDR, SRAM_WE, Triggered, Trigger_Addr, Capture_Done);
      end
      wes = 0;
      repeat (10) begin
         @(negedge CLK);
         if (SRAM_WE !== 1'b0) wes++;
      end
      rec = 1'b0;
      total++;
      if (wes != 0) begin bad++; $display("FAIL reset_post_we: got %0d write cycles want 0", wes); end
   endtask

   initial begin
      test_reset();
      test_free_run(0);
      test_free_run(2);
      test_trigger_gating();
      test_wrap();
      test_abort_win0();
      test_random();
      test_reset_mid_post();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
